// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for param_seq_alu: operation codes, FSM states, the
// iterative-core mode select and the bit positions of the packed flag vector.
// -----------------------------------------------------------------------------
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_XOR = 3'b010,
    OP_SHL = 3'b011,
    OP_SHR = 3'b100,
    OP_AND = 3'b101,
    OP_OR  = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    MODE_SHL = 2'd0,
    MODE_SHR = 2'd1,
    MODE_MUL = 2'd2
  } iter_mode_e;

  // Bit positions inside the registered flag vector.
  localparam int FLAG_CARRY = 0;
  localparam int FLAG_ZERO  = 1;
  localparam int FLAG_OVF   = 2;
  localparam int FLAG_ERR   = 3;
  localparam int FLAG_W     = 4;

  function automatic logic [FLAG_W-1:0] make_flags(input logic carry, input logic zero,
                                                   input logic ovf, input logic err);
    logic [FLAG_W-1:0] f;
    f             = '0;
    f[FLAG_CARRY] = carry;
    f[FLAG_ZERO]  = zero;
    f[FLAG_OVF]   = ovf;
    f[FLAG_ERR]   = err;
    return f;
  endfunction

endpackage

// File: rtl/param_seq_alu_if.sv
// -----------------------------------------------------------------------------
// param_seq_alu_if
// Operand/result handshake bundle of param_seq_alu.
//   master : operand source / result sink (register file + writeback side)
//   slave  : the ALU itself
// Signals: in_valid/in_ready/op/data1/data2 (operand channel),
//          out_valid/out_ready/result/carry/zero/ovf/err (result channel).
// -----------------------------------------------------------------------------
interface param_seq_alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             ovf;
  logic             err;

  modport master (
    output in_valid, op, data1, data2, out_ready,
    input  in_ready, out_valid, result, carry, zero, ovf, err
  );

  modport slave (
    input  in_valid, op, data1, data2, out_ready,
    output in_ready, out_valid, result, carry, zero, ovf, err
  );
endinterface

// File: rtl/alu_iter_core.sv
// -----------------------------------------------------------------------------
// alu_iter_core
// Shared multi-cycle datapath: 1-bit-per-cycle logical shift left/right and
// unsigned shift-add multiply, with its own step counter.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start_i         load operands and begin (ignored counts of 0 are never issued)
//   mode_i          SHL / SHR / MUL
//   a_i             value to shift, or multiplicand
//   b_i             multiplier (MUL only)
//   cnt_i           number of steps to run (>= 1)
//   done_o          high during the final step
//   result_o        value after the current step (valid with done_o)
//   carry_o         bit shifted out by the current step, or |high product
// -----------------------------------------------------------------------------
module alu_iter_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  iter_mode_e       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [CW-1:0]    cnt_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic             busy_q;
  iter_mode_e       mode_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] lo_q, lo_d;    // shift value, or multiplier / product low half
  logic [WIDTH-1:0] hi_q, hi_d;    // product high half
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH:0]   sum;
  logic             carry_d;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    lo_d    = lo_q;
    hi_d    = hi_q;
    carry_d = 1'b0;
    sum     = '0;
    case (mode_q)
      MODE_SHL: begin
        lo_d    = {lo_q[WIDTH-2:0], 1'b0};
        carry_d = lo_q[WIDTH-1];
      end
      MODE_SHR: begin
        lo_d    = {1'b0, lo_q[WIDTH-1:1]};
        carry_d = lo_q[0];
      end
      MODE_MUL: begin
        // Add multiplicand when the current multiplier LSB is set, then shift
        // the 2*WIDTH product right; the sum's carry enters the top.
        sum          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : '0);
        {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
        carry_d      = |hi_d;
      end
      default: ;
    endcase
  end

  assign done_o   = busy_q && (cnt_q == CW'(1));
  assign result_o = lo_d;
  assign carry_o  = carry_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is only seen on a rising clock edge.
    if (!rst_n) begin
      busy_q  <= 1'b0;
      mode_q  <= MODE_SHL;
      cnt_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      mcand_q <= '0;
    end else if (start_i) begin
      busy_q  <= 1'b1;
      mode_q  <= mode_i;
      cnt_q   <= cnt_i;
      lo_q    <= (mode_i == MODE_MUL) ? b_i : a_i;
      hi_q    <= '0;
      mcand_q <= a_i;
    end else if (busy_q) begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) busy_q <= 1'b0;
    end
  end

endmodule

// File: rtl/param_seq_alu.sv
// -----------------------------------------------------------------------------
// param_seq_alu
// Clocked WIDTH-bit ALU between the operand register file and writeback.
// Single-cycle ops (ADD/SUB/XOR/AND/OR) complete on the accept edge; shifts
// and multiply run in alu_iter_core. Result and flags are registered and held
// in DONE until out_ready.
// Ports:
//   clk, rst_n   clock, synchronous active-low reset
//   bus          param_seq_alu_if.slave: operand and result handshakes
// Build option:
//   ALU_MUL_EN   defined: op 111 is an iterative unsigned multiply;
//                undefined: op 111 is illegal (err=1, result=0).
// -----------------------------------------------------------------------------
module param_seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  param_seq_alu_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  state_e            state_q;
  logic [WIDTH-1:0]  result_q;
  logic [FLAG_W-1:0] flags_q;

  logic              accept;
  logic [WIDTH-1:0]  a, b;
  logic [WIDTH:0]    ext_sum, ext_diff;
  logic [CW-1:0]     amount;
  logic [WIDTH-1:0]  res_c;
  logic              carry_c, ovf_c, err_c, iter_c;
  iter_mode_e        mode_c;
  logic [CW-1:0]     cnt_c;

  logic              core_done;
  logic [WIDTH-1:0]  core_res;
  logic              core_carry;

  assign a      = bus.data1;
  assign b      = bus.data2;
  assign accept = bus.in_valid && (state_q == ST_IDLE);

  // Shift amounts saturate at WIDTH: everything has been shifted out by then.
  assign amount = ({1'b0, b} >= (WIDTH + 1)'(WIDTH)) ? CW'(WIDTH) : CW'(b);

  always_comb begin
    res_c    = '0;
    carry_c  = 1'b0;
    ovf_c    = 1'b0;
    err_c    = 1'b0;
    iter_c   = 1'b0;
    mode_c   = MODE_SHL;
    cnt_c    = amount;
    ext_sum  = {1'b0, a} + {1'b0, b};
    ext_diff = {1'b0, a} - {1'b0, b};
    case (op_e'(bus.op))
      OP_ADD: begin
        res_c   = ext_sum[WIDTH-1:0];
        carry_c = ext_sum[WIDTH];
        ovf_c   = (a[WIDTH-1] == b[WIDTH-1]) && (ext_sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c   = ext_diff[WIDTH-1:0];
        carry_c = ext_diff[WIDTH];  // borrow
        ovf_c   = (a[WIDTH-1] != b[WIDTH-1]) && (ext_diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_XOR: res_c = a ^ b;
      OP_AND: res_c = a & b;
      OP_OR:  res_c = a | b;
      OP_SHL, OP_SHR: begin
        // A zero shift completes immediately with the operand unchanged.
        res_c  = a;
        iter_c = (amount != '0);
        mode_c = (op_e'(bus.op) == OP_SHL) ? MODE_SHL : MODE_SHR;
      end
`ifdef ALU_MUL_EN
      OP_MUL: begin
        iter_c = 1'b1;
        mode_c = MODE_MUL;
        cnt_c  = CW'(WIDTH);
      end
`else
      OP_MUL: err_c = 1'b1;
`endif
      default: err_c = 1'b1;
    endcase
  end

  alu_iter_core #(.WIDTH(WIDTH), .CW(CW)) u_iter_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (accept && iter_c),
    .mode_i   (mode_c),
    .a_i      (a),
    .b_i      (b),
    .cnt_i    (cnt_c),
    .done_o   (core_done),
    .result_o (core_res),
    .carry_o  (core_carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (iter_c) begin
              state_q <= ST_EXEC;
            end else begin
              result_q <= res_c;
              flags_q  <= make_flags(carry_c, res_c == '0, ovf_c, err_c);
              state_q  <= ST_DONE;
            end
          end
        end
        ST_EXEC: begin
          if (core_done) begin
            result_q <= core_res;
            flags_q  <= make_flags(core_carry, core_res == '0, 1'b0, 1'b0);
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          // No new accept here: the earliest next accept is the following IDLE cycle.
          if (bus.out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry     = flags_q[FLAG_CARRY];
  assign bus.zero      = flags_q[FLAG_ZERO];
  assign bus.ovf       = flags_q[FLAG_OVF];
  assign bus.err       = flags_q[FLAG_ERR];

endmodule

// File: tb/tb_param_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_param_seq_alu
// Directed, table-driven bench for param_seq_alu at WIDTH=8, plus hand-written
// sequences for backpressure and reset during a shift.
// -----------------------------------------------------------------------------
module tb_param_seq_alu;

  localparam int WIDTH   = 8;
  localparam int MAX_LAT = 40;

  typedef struct {
    string      name;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       o;
    logic       e;
    int         lat;
  } vec_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  param_seq_alu_if #(.WIDTH(WIDTH)) bus ();

  param_seq_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Presents one operation, measures accept->out_valid latency, checks the
  // outputs, then releases the result with a one-cycle out_ready pulse.
  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    check({v.name, " in_ready"}, 32'(bus.in_ready), 32'd1);
    bus.in_valid  = 1'b1;
    bus.op        = v.op;
    bus.data1     = v.a;
    bus.data2     = v.b;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < MAX_LAT) begin
      @(negedge clk);
      lat++;
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " result"},  32'(bus.result), 32'(v.res));
    check({v.name, " carry"},   32'(bus.carry),  32'(v.c));
    check({v.name, " zero"},    32'(bus.zero),   32'(v.z));
    check({v.name, " ovf"},     32'(bus.ovf),    32'(v.o));
    check({v.name, " err"},     32'(bus.err),    32'(v.e));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({v.name, " back to idle"}, 32'(bus.in_ready), 32'd1);
  endtask

  vec_t vecs[15];

  initial begin
    vec_t v;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'b000;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.out_ready = 1'b0;

    //             name          op      a      b      res    c     z     o     e     lat
    vecs[0]  = '{"add_carry",   3'b000, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[1]  = '{"add_ovf",     3'b000, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[2]  = '{"sub_borrow",  3'b001, 8'h10, 8'h20, 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0, 1};
    vecs[3]  = '{"sub_ovf",     3'b001, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 1};
    vecs[4]  = '{"sub_zero",    3'b001, 8'h05, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[5]  = '{"xor_zero",    3'b010, 8'h5A, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1};
    vecs[6]  = '{"and",         3'b101, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[7]  = '{"or",          3'b110, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{"shl_3",       3'b011, 8'h81, 8'd3,  8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 4};
    vecs[9]  = '{"shr_1",       3'b100, 8'h81, 8'd1,  8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[10] = '{"shl_9_sat",   3'b011, 8'hFF, 8'd9,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 9};
    vecs[11] = '{"shl_0",       3'b011, 8'hA5, 8'd0,  8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1};
    vecs[12] = '{"shr_8",       3'b100, 8'h80, 8'd8,  8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 9};
    vecs[13] = '{"shr_2",       3'b100, 8'h06, 8'd2,  8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 3};
`ifdef ALU_MUL_EN
    vecs[14] = '{"mul",         3'b111, 8'h12, 8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 9};
`else
    vecs[14] = '{"mul_illegal", 3'b111, 8'h12, 8'h10, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1};
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst out_valid", 32'(bus.out_valid), 32'd0);
    check("rst in_ready",  32'(bus.in_ready),  32'd1);
    check("rst result",    32'(bus.result),    32'd0);
    check("rst flags",     32'({bus.carry, bus.zero, bus.ovf, bus.err}), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Backpressure: result held in DONE, new operands ignored.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = 3'b000;
    bus.data1    = 8'h03;
    bus.data2    = 8'h04;
    @(negedge clk);
    bus.op    = 3'b010;
    bus.data1 = 8'hFF;
    bus.data2 = 8'h0F;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp out_valid %0d", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp result %0d", i),    32'(bus.result),    32'h07);
      check($sformatf("bp in_ready %0d", i),  32'(bus.in_ready),  32'd0);
      check($sformatf("bp flags %0d", i), 32'({bus.carry, bus.zero, bus.ovf, bus.err}), 32'd0);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp no accept in DONE", 32'(bus.out_valid), 32'd0);
    check("bp idle after release", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp still idle", 32'(bus.in_ready), 32'd1);

    // Reset during EXEC of SHL by 7.
    bus.in_valid = 1'b1;
    bus.op       = 3'b011;
    bus.data1    = 8'hFF;
    bus.data2    = 8'd7;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid exec busy", 32'(bus.in_ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst result",    32'(bus.result),    32'd0);
    check("midrst in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("midrst no stray done", 32'(bus.out_valid), 32'd0);

    // Recovery after reset.
    v = vecs[8];
    v.name = "shl_3_after_rst";
    run_vec(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
